stall_ctrl: RTL

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush control: register-hazard stall plus a multiply/divide busy counter.
// Build option STALL_CTRL_PERF_EN adds a 32-bit StallCnt performance counter.
module stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [1:0]  TuseRsD,
  input  logic [1:0]  TuseRtD,
  input  logic [4:0]  WAE,
  input  logic [1:0]  TnewE,
  input  logic        RegWriteE,
  input  logic [4:0]  WAM,
  input  logic [1:0]  TnewM,
  input  logic        RegWriteM,
  input  logic        MDStartE,
  input  logic        MDIsDivE,
  input  logic        MDUseD,
`ifdef STALL_CTRL_PERF_EN
  output logic [31:0] StallCnt,
`endif
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        MDBusy,
  output logic [3:0]  MDCount
);

  localparam logic [3:0] LP_MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] LP_DIV_LOAD  = 4'(DIV_CYC);

  logic [3:0] r_md_count;
  logic       w_md_busy;
  logic       w_hazard_rs;
  logic       w_hazard_rt;
  logic       w_hazard_md;
  logic       w_stall;

  assign w_md_busy = (r_md_count != 4'd0);

  // A Tuse of 3 means the operand is never read, so it cannot hazard.
  always_comb begin
    w_hazard_rs = 1'b0;
    w_hazard_rt = 1'b0;
    if ((RsD != 5'd0) && (TuseRsD != 2'd3)) begin
      w_hazard_rs = (RegWriteE && (WAE == RsD) && (TnewE > TuseRsD)) ||
                    (RegWriteM && (WAM == RsD) && (TnewM > TuseRsD));
    end
    if ((RtD != 5'd0) && (TuseRtD != 2'd3)) begin
      w_hazard_rt = (RegWriteE && (WAE == RtD) && (TnewE > TuseRtD)) ||
                    (RegWriteM && (WAM == RtD) && (TnewM > TuseRtD));
    end
  end

  assign w_hazard_md = MDUseD && (MDStartE || w_md_busy);
  assign w_stall     = w_hazard_rs || w_hazard_rt || w_hazard_md;

  // A start while the unit is still counting is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_count <= 4'd0;
    end else if (MDStartE && !w_md_busy) begin
      r_md_count <= MDIsDivE ? LP_DIV_LOAD : LP_MULT_LOAD;
    end else if (w_md_busy) begin
      r_md_count <= r_md_count - 4'd1;
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
`endif

  assign StallF  = w_stall;
  assign StallD  = w_stall;
  assign FlushE  = w_stall;
  assign MDBusy  = w_md_busy;
  assign MDCount = r_md_count;

endmodule
